// File: rtl/ffra_pipe.sv
// rtl/ffra_pipe.sv - chunked carry-pipelined adder/subtractor with valid/ready flow control
module ffra_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             co,
    output logic             ovf,
    output logic [15:0]      done_cnt
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("ffra_pipe: WIDTH must be an integer multiple of STAGES");
    end

    // ra[k] holds the result chunks 0..k plus the untouched upper chunks of operand A
    logic [WIDTH-1:0]  ra     [STAGES];
    logic [WIDTH-1:0]  rb     [STAGES];
    logic [STAGES-1:0] rc, rv, ram, rbm;

    logic [WIDTH-1:0]  src_a  [STAGES];
    logic [WIDTH-1:0]  src_b  [STAGES];
    logic [WIDTH-1:0]  nx_a   [STAGES];
    logic [CHUNK:0]    sum    [STAGES];
    logic [STAGES-1:0] src_c, src_v, src_am, src_bm, nx_c;

    logic stall;

    assign out_valid = rv[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = rst || !stall;

    assign o   = ra[STAGES-1];
    assign co  = rc[STAGES-1];
    assign ovf = (ram[STAGES-1] == rbm[STAGES-1]) && (o[WIDTH-1] != ram[STAGES-1]);

    always_comb begin
        src_a[0]  = a;
        src_b[0]  = sub ? ~b : b;
        src_c[0]  = sub ? ~ci : ci;
        src_v[0]  = in_valid;
        src_am[0] = a[WIDTH-1];
        src_bm[0] = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]  = ra[k-1];
            src_b[k]  = rb[k-1];
            src_c[k]  = rc[k-1];
            src_v[k]  = rv[k-1];
            src_am[k] = ram[k-1];
            src_bm[k] = rbm[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                    + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_c[k]};
            nx_a[k] = src_a[k];
            nx_a[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
            nx_c[k] = sum[k][CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv       <= '0;
            rc       <= '0;
            ram      <= '0;
            rbm      <= '0;
            done_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
            end
        end else begin
            if (!stall) begin
                rv  <= src_v;
                rc  <= nx_c;
                ram <= src_am;
                rbm <= src_bm;
                for (int k = 0; k < STAGES; k++) begin
                    ra[k] <= nx_a[k];
                    rb[k] <= src_b[k];
                end
            end
            if (out_valid && out_ready) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule
